// File: rtl/window3x3_gen_if.sv
// Handshake and window bundle between a pixel source/window sink and window3x3_gen.
// The generator takes the slave view; the surrounding stage or bench takes the master view.
interface window3x3_gen_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_sof;
  logic              w_valid;
  logic              w_ready;
  logic              w_last;
  logic [DATA_W-1:0] p00, p01, p02;
  logic [DATA_W-1:0] p10, p11, p12;
  logic [DATA_W-1:0] p20, p21, p22;

  modport master (
    output s_valid, s_data, s_sof, w_ready,
    input  s_ready, w_valid, w_last,
    input  p00, p01, p02, p10, p11, p12, p20, p21, p22
  );

  modport slave (
    input  s_valid, s_data, s_sof, w_ready,
    output s_ready, w_valid, w_last,
    output p00, p01, p02, p10, p11, p12, p20, p21, p22
  );
endinterface

// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3-column shift window,
// emitting one interior-centred window per accepted pixel through a single output register.
module window3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic          clk,
  input  logic          rst_n,
  window3x3_gen_if.slave bus
);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0]  col, cur_col;
  logic [ROW_W-1:0]  row, cur_row;
  logic              accept;
  logic              at_last_col, at_last_row;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] a, b;

  logic              w_valid_q, w_last_q;
  logic [DATA_W-1:0] p00_q, p01_q, p02_q;
  logic [DATA_W-1:0] p10_q, p11_q, p12_q;
  logic [DATA_W-1:0] p20_q, p21_q, p22_q;

  assign accept = bus.s_valid && bus.s_ready;

  // A start-of-frame pixel is placed at (0,0) regardless of where the counters were.
  assign cur_col     = bus.s_sof ? '0 : col;
  assign cur_row     = bus.s_sof ? '0 : row;
  assign at_last_col = (cur_col == COL_W'(IMG_W - 1));
  assign at_last_row = (cur_row == ROW_W'(IMG_H - 1));

  assign a = lb1[cur_col];
  assign b = lb0[cur_col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_last_col) begin
        col <= '0;
        row <= at_last_row ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // Line buffers are never cleared; stale entries only reach windows the emission rule suppresses.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[cur_col] <= bus.s_data;
      lb1[cur_col] <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      p00_q <= '0; p01_q <= '0; p02_q <= '0;
      p10_q <= '0; p11_q <= '0; p12_q <= '0;
      p20_q <= '0; p21_q <= '0; p22_q <= '0;
    end else if (accept) begin
      p00_q <= p01_q; p01_q <= p02_q; p02_q <= a;
      p10_q <= p11_q; p11_q <= p12_q; p12_q <= b;
      p20_q <= p21_q; p21_q <= p22_q; p22_q <= bus.s_data;
      w_valid_q <= (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      w_last_q  <= at_last_row && at_last_col;
    end else if (bus.w_ready) begin
      w_valid_q <= 1'b0;
    end
  end

  // A new pixel may enter whenever the output register is empty or being drained this cycle.
  assign bus.s_ready = !w_valid_q || bus.w_ready;
  assign bus.w_valid = w_valid_q;
  assign bus.w_last  = w_last_q;
  assign bus.p00 = p00_q;
  assign bus.p01 = p01_q;
  assign bus.p02 = p02_q;
  assign bus.p10 = p10_q;
  assign bus.p11 = p11_q;
  assign bus.p12 = p12_q;
  assign bus.p20 = p20_q;
  assign bus.p21 = p21_q;
  assign bus.p22 = p22_q;
endmodule
